mrdy_waitgen: RTL and testbench
===============================

// Module: mrdy_waitgen
// PURPOSE
// Wait-state generator that drives MRDY into the mmu clock generator (QX/EX on CLKX4).
// Decodes the active chip select for the current bus cycle and holds MRDY low to stretch
// the E-high phase by a per-device number of CLKX4 periods. EXT/EXTIO cycles are further
// extended by the external bus EXT_nWAIT line, with a timeout guard and a sticky flag.
// PARAMETERS
// WS_ROM0    1    extra CLKX4 periods of E-high for nCSROM0 cycles (0..2**CNT_W-1)
// WS_ROM1    1    extra periods for nCSROM1 cycles
// WS_RAM     0    extra periods for nCSRAM cycles
// WS_UART    2    extra periods for nCSUART cycles
// WS_EXT     2    extra periods for nCSEXT cycles, before EXT_nWAIT is honoured
// WS_EXTIO   3    extra periods for nCSEXTIO cycles, before EXT_nWAIT is honoured
// CNT_W      4    wait-state counter width
// TIMEOUT    255  maximum CLKX4 periods spent in EXT_nWAIT hold (1..2**TO_W-1)
// TO_W       8    timeout counter width
// PORTS
// CLKX4      in   1  4x E clock; all state changes on posedge
// RESET      in   1  asynchronous, active-high reset
// QX         in   1  Q phase from mmu clock generator
// EX         in   1  E phase from mmu clock generator
// BA         in   1  CPU bus available; 1 = no CPU cycle, never stretch
// nCSROM0    in   1  chip selects from mmu, active low
// nCSROM1    in   1
// nCSRAM     in   1
// nCSUART    in   1
// nCSEXT     in   1
// nCSEXTIO   in   1
// EXT_nWAIT  in   1  external bus wait request, active low, asynchronous
// MRDY       out  1  memory ready to clock generator; 0 = hold E high
// WAITING    out  1  1 while a cycle is being stretched (== !MRDY)
// TMO        out  1  sticky: an EXT_nWAIT hold hit TIMEOUT
// BEHAVIOUR
// - Reset (async): state IDLE, cnt=0, tcnt=0, sync flops=1, TMO=0, MRDY=1, WAITING=0.
// - EXT_nWAIT passes through a 2-flop synchronizer (reset value 1) -> nwait_s.
// - Phase decode {QX,EX}: 00 -> 10 -> 11 -> 01 (01 = E high, Q low; stall state).
// - Select priority when several are low: EXTIO > UART > EXT > ROM1 > ROM0 > RAM; none -> 0.
// - States: IDLE, COUNT, EXTHOLD. MRDY = (state==IDLE), registered-state decode only.
// - IDLE: on edge with {QX,EX}==11 and BA==0: WS = selected device value.
//   WS>0 -> cnt<=WS-1, latch is_ext (EXT/EXTIO), go COUNT; WS==0 and is_ext -> go EXTHOLD.
//   Otherwise stay IDLE.
// - COUNT: only on edges with {QX,EX}==01. cnt!=0 -> cnt<=cnt-1.
//   cnt==0 -> is_ext ? EXTHOLD (tcnt<=0) : IDLE.
// - EXTHOLD: on edges with {QX,EX}==01: nwait_s==1 -> IDLE.
//   Otherwise, if tcnt==TIMEOUT-1 -> IDLE and TMO<=1; else tcnt<=tcnt+1.
// - Latency: WS=N adds exactly N CLKX4 periods of E-high for non-ext cycles (N=0: none).
//   The clock generator releases on the first 01 edge at which MRDY==1.
// - Any edge in COUNT/EXTHOLD with {QX,EX} not in {11,01} (illegal, clkgen glitch):
//   force IDLE; do not set TMO.
// - BA==1 at the 11 edge: no stretch regardless of selects.
// - Selects are sampled only at the 11 edge; changes later in the cycle are ignored.
// - Counters never wrap: cnt saturates at 0 and tcnt is bounded by TIMEOUT.
// - TMO is cleared only by RESET.
// - RESET mid-stretch: MRDY=1 immediately; the next cycle decodes fresh.
// TESTING
// - RAM cycle, WS_RAM=0, BA=0: MRDY stays 1; E-high lasts 2 CLKX4 periods (clkgen model).
// - ROM0 cycle, WS_ROM0=2: MRDY=0 for exactly 2 stall edges; E-high = 4 CLKX4 periods.
// - EXTIO, WS_EXTIO=3, EXT_nWAIT low for 6 edges then high:
//   MRDY rises 3 (count) + hold + 2 (sync) edges later; TMO=0.
// - EXT, EXT_nWAIT stuck low, TIMEOUT=8: release after WS_EXT+8 stall edges; TMO=1,
//   stays 1 over later cycles.
// - nCSUART and nCSRAM both low, WS_UART=2: UART wins, 2-period stretch;
//   BA=1 with nCSUART low: no stretch.
// - RESET pulsed while in COUNT with cnt=2: MRDY=1, WAITING=0 asynchronously;
//   the next ROM1 cycle stretches by WS_ROM1.

Source files
------------

// File: rtl/mrdy_waitgen.sv
// mrdy_waitgen: wait-state generator holding MRDY low to stretch E-high per chip select
// Ports:
//   i_clkx4              4x E clock, all state changes on posedge
//   i_reset              asynchronous active-high reset
//   i_qx, i_ex           Q/E phase from the clock generator
//   i_ba                 bus available; 1 = no CPU cycle, never stretch
//   i_ncs_*              active-low chip selects (rom0, rom1, ram, uart, ext, extio)
//   i_ext_nwait          external bus wait request, active low, asynchronous
//   o_mrdy               0 = hold E high
//   o_waiting            1 while a cycle is being stretched
//   o_tmo                sticky flag: an external wait hold hit TIMEOUT
module mrdy_waitgen #(
  parameter int WS_ROM0  = 1,
  parameter int WS_ROM1  = 1,
  parameter int WS_RAM   = 0,
  parameter int WS_UART  = 2,
  parameter int WS_EXT   = 2,
  parameter int WS_EXTIO = 3,
  parameter int CNT_W    = 4,
  parameter int TIMEOUT  = 255,
  parameter int TO_W     = 8
) (
  input  logic i_clkx4,
  input  logic i_reset,
  input  logic i_qx,
  input  logic i_ex,
  input  logic i_ba,
  input  logic i_ncs_rom0,
  input  logic i_ncs_rom1,
  input  logic i_ncs_ram,
  input  logic i_ncs_uart,
  input  logic i_ncs_ext,
  input  logic i_ncs_extio,
  input  logic i_ext_nwait,
  output logic o_mrdy,
  output logic o_waiting,
  output logic o_tmo
);
  typedef enum logic [1:0] {IDLE, COUNT, EXTHOLD} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [TO_W-1:0]  r_tcnt;
  logic [1:0]       r_sync;
  logic             r_is_ext;
  logic             r_tmo;
  logic [CNT_W-1:0] w_ws;
  logic             w_ext;
  logic [1:0]       w_ph;
  assign w_ph = {i_qx, i_ex};
  // priority EXTIO > UART > EXT > ROM1 > ROM0 > RAM
  always_comb begin
    w_ws  = !i_ncs_extio ? CNT_W'(WS_EXTIO) :
            !i_ncs_uart  ? CNT_W'(WS_UART)  :
            !i_ncs_ext   ? CNT_W'(WS_EXT)   :
            !i_ncs_rom1  ? CNT_W'(WS_ROM1)  :
            !i_ncs_rom0  ? CNT_W'(WS_ROM0)  :
            !i_ncs_ram   ? CNT_W'(WS_RAM)   : '0;
    w_ext = !i_ncs_extio || (i_ncs_uart && !i_ncs_ext);
  end
  always_ff @(posedge i_clkx4 or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_tcnt   <= '0;
      r_sync   <= 2'b11;
      r_is_ext <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_ext_nwait};
      case (r_state)
        IDLE: if (w_ph == 2'b11 && !i_ba) begin
          r_is_ext <= w_ext;
          r_tcnt   <= '0;
          if (w_ws != '0) begin
            r_cnt   <= w_ws - 1'b1;
            r_state <= COUNT;
          end else if (w_ext) r_state <= EXTHOLD;
        end
        COUNT: if (w_ph == 2'b01) begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else begin
            r_tcnt  <= '0;
            r_state <= r_is_ext ? EXTHOLD : IDLE;
          end
        end else if (w_ph != 2'b11) r_state <= IDLE;
        EXTHOLD: if (w_ph == 2'b01) begin
          if (r_sync[1]) r_state <= IDLE;
          else if (r_tcnt == TO_W'(TIMEOUT - 1)) begin
            r_state <= IDLE;
            r_tmo   <= 1'b1;
          end else r_tcnt <= r_tcnt + 1'b1;
        end else if (w_ph != 2'b11) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_mrdy    = (r_state == IDLE);
  assign o_waiting = (r_state != IDLE);
  assign o_tmo     = r_tmo;
endmodule

// File: tb/tb_mrdy_waitgen.sv
// tb_mrdy_waitgen: randomized and directed checks of mrdy_waitgen against a stall-count model
module tb_mrdy_waitgen;
  localparam int TO = 8;
  logic clk = 0, rst = 1, qx = 0, ex = 0, ba = 0, nw = 1;
  logic [5:0] ncs = '1;
  logic o_mrdy, o_waiting, o_tmo;
  always #5 clk = ~clk;
  mrdy_waitgen #(
    .WS_ROM0(2), .WS_ROM1(1), .WS_RAM(0), .WS_UART(2), .WS_EXT(2), .WS_EXTIO(3),
    .CNT_W(4), .TIMEOUT(TO), .TO_W(8)
  ) dut (
    .i_clkx4(clk), .i_reset(rst), .i_qx(qx), .i_ex(ex), .i_ba(ba),
    .i_ncs_rom0(ncs[1]), .i_ncs_rom1(ncs[2]), .i_ncs_ram(ncs[0]),
    .i_ncs_uart(ncs[4]), .i_ncs_ext(ncs[3]), .i_ncs_extio(ncs[5]),
    .i_ext_nwait(nw), .o_mrdy(o_mrdy), .o_waiting(o_waiting), .o_tmo(o_tmo)
  );
  int errors = 0, checks = 0;
  logic [1:0] ph = 2'b00;
  logic m = 1;
  int stalls = 0;
  int left, tc;
  logic hold, xp, mtmo, h1, h2;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // ncs bits in priority order: {extio, uart, ext, rom1, rom0, ram}
  function automatic int ws_of(input logic [5:0] s, output logic x);
    x = !s[5] || (s[4] && !s[3]);
    if (!s[5]) return 3;
    if (!s[4]) return 2;
    if (!s[3]) return 2;
    if (!s[2]) return 1;
    if (!s[1]) return 2;
    return 0;
  endfunction
  function automatic logic [1:0] adv(input logic [1:0] p, input logic r);
    return p == 2'b00 ? 2'b10 : p == 2'b10 ? 2'b11 : p == 2'b11 ? 2'b01 : (r ? 2'b00 : 2'b01);
  endfunction
  task automatic model_reset();
    left = 0; tc = 0; hold = 0; xp = 0; mtmo = 0; h1 = 1; h2 = 1;
  endtask
  task automatic model_edge();
    logic ns, x;
    int w;
    ns = h2; h2 = h1; h1 = nw;
    if (left == 0 && !hold) begin
      if ({qx, ex} == 2'b11 && !ba) begin
        w = ws_of(ncs, x);
        if (w > 0) begin left = w; xp = x; end
        else if (x) begin hold = 1; tc = 0; end
      end
    end else if ({qx, ex} == 2'b01) begin
      if (left > 0) begin
        left--;
        if (left == 0 && xp) begin hold = 1; tc = 0; end
      end else if (ns) hold = 0;
      else begin
        tc++;
        if (tc == TO) begin hold = 0; mtmo = 1; end
      end
    end else if ({qx, ex} != 2'b11) begin
      left = 0; hold = 0;
    end
  endtask
  task automatic step();
    logic e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (ph == 2'b01 && !m) stalls++;
    ph = adv(ph, m);
    qx = ph[1]; ex = ph[0];
    m = o_mrdy;
    e = (left == 0 && !hold);
    chk("mrdy", o_mrdy, e);
    chk("waiting", o_waiting, !e);
    chk("tmo", o_tmo, mtmo);
  endtask
  task automatic pulse_reset();
    rst = 1;
    model_reset();
    #1;
    chk("rst_mrdy", o_mrdy, 1);
    chk("rst_waiting", o_waiting, 0);
    chk("rst_tmo", o_tmo, 0);
    #1 rst = 0;
    m = o_mrdy;
  endtask
  task automatic run_cycle(input logic [5:0] sel, input logic b, input logic nw0, input int k,
                           output int eh, output int lo);
    int n;
    ncs = sel; ba = b; nw = nw0; eh = 0; lo = 0; stalls = 0; n = 0;
    do begin
      if (ex) eh++;
      if (!o_mrdy) lo++;
      step();
      n++;
      if (stalls == k) nw = 1;
    end while (ph != 2'b00 && n < 100);
    chk("cycle_end_phase", ph, 2'b00);
    ncs = '1; ba = 0;
  endtask
  initial begin
    int eh, lo;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_mrdy", o_mrdy, 1);
    chk("reset_waiting", o_waiting, 0);
    chk("reset_tmo", o_tmo, 0);
    rst = 0;
    m = o_mrdy;
    run_cycle(6'b111110, 0, 1, 0, eh, lo);
    chk("ram_ehigh", eh, 2); chk("ram_low", lo, 0);
    run_cycle(6'b111101, 0, 1, 0, eh, lo);
    chk("rom0_ehigh", eh, 4); chk("rom0_low", lo, 2);
    run_cycle(6'b101110, 0, 1, 0, eh, lo);
    chk("uart_ram_ehigh", eh, 4); chk("uart_ram_low", lo, 2);
    run_cycle(6'b101111, 1, 1, 0, eh, lo);
    chk("ba_uart_ehigh", eh, 2); chk("ba_uart_low", lo, 0);
    run_cycle(6'b011111, 0, 0, 6, eh, lo);
    chk("extio_ehigh", eh, 11); chk("extio_low", lo, 9); chk("extio_tmo", o_tmo, 0);
    run_cycle(6'b110111, 0, 0, 1000, eh, lo);
    chk("ext_to_ehigh", eh, 12); chk("ext_to_low", lo, 10); chk("ext_to_tmo", o_tmo, 1);
    run_cycle(6'b111110, 0, 1, 0, eh, lo);
    chk("tmo_sticky", o_tmo, 1); chk("ram2_ehigh", eh, 2);
    ncs = 6'b011111; ba = 0;
    repeat (3) step();
    chk("count_mrdy", o_mrdy, 0);
    pulse_reset();
    ncs = '1;
    for (int i = 0; i < 10 && ph != 2'b00; i++) step();
    chk("post_reset_phase", ph, 2'b00);
    run_cycle(6'b111011, 0, 1, 0, eh, lo);
    chk("rom1_ehigh", eh, 3); chk("rom1_low", lo, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) pulse_reset();
      for (int j = 0; j < 6; j++) ncs[j] = ($urandom_range(0, 3) != 0);
      ba = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) nw = 1'($urandom_range(0, 1));
      step();
      if ($urandom_range(0, 49) == 0) begin
        ph = 2'($urandom_range(0, 3));
        qx = ph[1]; ex = ph[0];
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
